// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: in_kind enumeration, major opcodes and encoder FSM states.
package mips_pkg;

    typedef enum logic [2:0] {
        KIND_R    = 3'd0,
        KIND_LW   = 3'd1,
        KIND_SW   = 3'd2,
        KIND_BEQ  = 3'd3,
        KIND_ADDI = 3'd4,
        KIND_J    = 3'd5
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_WRITE = 2'd2,
        ST_FULL  = 2'd3
    } enc_state_e;

endpackage

// File: rtl/instr_pack_32.sv
// Combinational packing of an instruction request into a 32-bit MIPS word.
// Latency 0; kinds 6 and 7 yield word 0 with illegal raised.
module instr_pack_32 import mips_pkg::*; (
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            KIND_R:    word = {OP_RTYPE, rs, rt, rd, 5'd0, funct};
            KIND_LW:   word = {OP_LW,    rs, rt, imm};
            KIND_SW:   word = {OP_SW,    rs, rt, imm};
            KIND_BEQ:  word = {OP_BEQ,   rs, rt, imm};
            KIND_ADDI: word = {OP_ADDI,  rs, rt, imm};
            KIND_J:    word = {OP_J,     target};
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_32.sv
// Encodes instruction requests and streams them into instruction memory, one word per 2 cycles peak.
// Latency: imem_we rises the cycle after a transfer; the write is held until imem_ack.
module instr_encoder_32 import mips_pkg::*; #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err_illegal_kind
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;

    logic [31:0] packed_word;
    logic        packed_illegal;

    instr_pack_32 u_pack (
        .kind    (in_kind),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .funct   (in_funct),
        .imm     (in_imm),
        .target  (in_target),
        .word    (packed_word),
        .illegal (packed_illegal)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            ST_WRITE: begin
                if (imem_ack) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    count_d = count_q + (ADDR_W+1)'(1);
                    state_d = (count_d == FULL_CNT) ? ST_FULL : ST_READY;
                end
            end
            default: begin
                // start opens a fresh session and wins over a concurrent transfer
                if (start) begin
                    addr_d  = BASE;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_READY;
                end else if (state_q == ST_READY && in_valid) begin
                    if (packed_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        wdata_d = packed_word;
                        state_d = ST_WRITE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE;
            count_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs decode straight from the state so reset clears them immediately.
    assign in_ready         = (state_q == ST_READY);
    assign imem_we          = (state_q == ST_WRITE);
    assign full             = (state_q == ST_FULL);
    assign imem_addr        = addr_q;
    assign imem_wdata       = wdata_q;
    assign count            = count_q;
    assign err_illegal_kind = err_q;

endmodule

// File: tb/tb_instr_encoder_32.sv
// Scoreboard bench for instr_encoder_32 with a small memory (ADDR_W=2) so that FULL is reachable.
module tb_instr_encoder_32;

    localparam int TB_AW = 2;
    localparam int DEPTH = 1 << TB_AW;

    logic              clk = 1'b0;
    logic              rst_n, start, in_valid, in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rs, in_rt, in_rd;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we, imem_ack, full, err_illegal_kind;
    logic [TB_AW-1:0]  imem_addr;
    logic [31:0]       imem_wdata;
    logic [TB_AW:0]    count;

    instr_encoder_32 #(.ADDR_W(TB_AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
        .in_imm(in_imm), .in_target(in_target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ack(imem_ack), .count(count), .full(full),
        .err_illegal_kind(err_illegal_kind)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding from the instruction-format table, using plain arithmetic.
    function automatic logic [31:0] ref_word(input int k, input longint rs, input longint rt,
                                             input longint rd, input longint fn,
                                             input longint imm, input longint tgt);
        longint op;
        longint w;
        case (k)
            1: op = 35;
            2: op = 43;
            3: op = 4;
            4: op = 8;
            5: op = 2;
            default: op = 0;
        endcase
        if (k == 0)      w = rs * (2**21) + rt * (2**16) + rd * (2**11) + fn;
        else if (k == 5) w = op * (2**26) + tgt;
        else             w = op * (2**26) + rs * (2**21) + rt * (2**16) + imm;
        return w[31:0];
    endfunction

    // Behavioural model of the session.
    bit          m_session, m_pending, m_full, m_err;
    int          m_addr, m_count;
    logic [31:0] sb[$];
    logic [31:0] last_word;
    int          last_addr, n_writes, we_cycles, cyc, last_xfer, xfer_gap;
    int          ack_delay = 0;
    bit          ack_noise = 0;

    initial begin
        int wcnt = 0;
        imem_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (imem_we) begin
                imem_ack = (wcnt >= ack_delay);
                wcnt++;
            end else begin
                wcnt = 0;
                imem_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // Monitor: compares every cycle, pops the scoreboard when a write is acknowledged.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_we", imem_we, 0);
                chk("rst_ready", in_ready, 0);
                chk("rst_addr", imem_addr, 0);
                chk("rst_count", count, 0);
                chk("rst_full", full, 0);
                chk("rst_err", err_illegal_kind, 0);
                chk("rst_wdata", imem_wdata, 0);
                m_session = 0; m_pending = 0; m_full = 0; m_err = 0;
                m_addr = 0; m_count = 0;
                sb.delete();
            end else begin
                bit was_pending;
                was_pending = m_pending;
                chk("in_ready", in_ready, m_session && !m_pending && !m_full);
                chk("imem_we", imem_we, m_pending);
                chk("full", full, m_full);
                chk("count", count, m_count);
                chk("err", err_illegal_kind, m_err);
                chk("imem_addr", imem_addr, m_addr);
                if (m_pending && sb.size() > 0) chk("imem_wdata", imem_wdata, sb[0]);
                if (imem_we) we_cycles++;
                if (was_pending && imem_ack) begin
                    if (sb.size() == 0) begin
                        chk("sb_empty_pop", 1, 0);
                    end else begin
                        chk("write_word", imem_wdata, sb.pop_front());
                    end
                    last_word = imem_wdata;
                    last_addr = int'(imem_addr);
                    n_writes++;
                    m_addr  = (m_addr + 1) % DEPTH;
                    m_count = m_count + 1;
                    m_pending = 0;
                    if (m_count == DEPTH) m_full = 1;
                end else if (start && !was_pending) begin
                    m_session = 1; m_full = 0; m_err = 0;
                    m_addr = 0; m_count = 0;
                end else if (in_valid && m_session && !was_pending && !m_full) begin
                    xfer_gap  = cyc - last_xfer;
                    last_xfer = cyc;
                    if (in_kind > 3'd5) m_err = 1;
                    else begin
                        sb.push_back(ref_word(int'(in_kind), in_rs, in_rt, in_rd,
                                              in_funct, in_imm, in_target));
                        m_pending = 1;
                        we_cycles = 0;
                    end
                end
            end
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int k, input int rs, input int rt, input int rd,
                        input int fn, input int imm, input int tgt);
        int guard = 0;
        in_kind = 3'(k); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_funct = 6'(fn); in_imm = 16'(imm); in_target = 26'(tgt);
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            guard++;
        end while (!in_ready && guard < 40);
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_not_pending();
        int guard = 0;
        while (m_pending && guard < 30) begin
            @(posedge clk); #1;
            guard++;
        end
        if (m_pending) chk("ack_timeout", 0, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_funct = '0; in_imm = '0; in_target = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", in_ready, 0);

        do_start();
        send(0, 1, 2, 3, 'h20, 0, 0);
        wait_not_pending();
        chk("rtype_word", last_word, 32'h00221820);
        chk("rtype_addr", last_addr, 0);
        chk("rtype_count", count, 1);

        do_start();
        send(1, 16, 8, 0, 0, 4, 0);
        wait_not_pending();
        chk("lw_word", last_word, 32'h8E080004);
        chk("lw_addr", last_addr, 0);
        send(3, 1, 2, 0, 0, 'hFFFF, 0);
        wait_not_pending();
        chk("beq_word", last_word, 32'h1022FFFF);
        chk("beq_addr", last_addr, 1);

        do_start();
        ack_delay = 3;
        send(5, 0, 0, 0, 0, 0, 'h10);
        wait_not_pending();
        chk("j_word", last_word, 32'h08000010);
        chk("j_hold_cycles", we_cycles, 4);
        ack_delay = 0;

        do_start();
        send(6, 9, 9, 9, 9, 9, 9);
        send(4, 0, 5, 0, 0, 7, 0);
        wait_not_pending();
        chk("illegal_err", err_illegal_kind, 1);
        chk("addi_word", last_word, 32'h20050007);
        chk("addi_count", count, 1);

        do_start();
        n_writes = 0;
        for (int i = 0; i < DEPTH; i++) send(2, i, i + 1, 0, 0, i * 3, 0);
        wait_not_pending();
        chk("peak_gap", xfer_gap, 2);
        chk("full_writes", n_writes, DEPTH);
        chk("full_flag", full, 1);
        chk("full_ready", in_ready, 0);
        chk("full_addr_wrap", imem_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("full_no_write", imem_we, 0);
        do_start();
        chk("restart_count", count, 0);
        chk("restart_addr", imem_addr, 0);
        chk("restart_ready", in_ready, 1);

        // start and a transfer together: the transfer is dropped
        in_kind = 3'd1; in_valid = 1'b1;
        do_start();
        in_valid = 1'b0;
        chk("start_prio_we", imem_we, 0);
        chk("start_prio_ready", in_ready, 1);

        ack_delay = 5;
        send(1, 3, 4, 0, 0, 100, 0);
        chk("pre_rst_we", imem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", imem_we, 0);
        chk("rst_mid_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_delay = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_ready", in_ready, 0);
        chk("post_rst_we", imem_we, 0);
        do_start();
        chk("post_rst_start", in_ready, 1);

        ack_noise = 1;
        repeat (300) begin
            if ($urandom_range(0, 9) == 0) begin
                do_start();
            end else begin
                wait_not_pending();
                if (m_full || !m_session) do_start();
                else begin
                    ack_delay = $urandom_range(0, 3);
                    send($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(0, 31), $urandom_range(0, 63),
                         $urandom_range(0, 65535), $urandom_range(0, (1 << 26) - 1));
                end
            end
        end
        wait_not_pending();
        ack_noise = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
